// File: rtl/dm_mport_arbiter.sv
// Multi-port memory arbiter: round-robin scan grants up to two clients per cycle
// into a shared 2**AW x DW store, refusing same-address pairs that involve a write.
module dm_mport_arbiter #(
    parameter int NPORTS = 4,
    parameter int DW     = 16,
    parameter int AW     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    req_i,
    input  logic [NPORTS-1:0]    we_i,
    input  logic [NPORTS*AW-1:0] addr_i,
    input  logic [NPORTS*DW-1:0] wdata_i,
    output logic [NPORTS-1:0]    gnt_o,
    output logic [NPORTS-1:0]    rvalid_o,
    output logic [NPORTS*DW-1:0] rdata_o,
    output logic [15:0]          conflict_cnt_o
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [PW:0]   NP_W  = (PW+1)'(NPORTS);
    localparam logic [PW-1:0] LAST_P = PW'(NPORTS - 1);

    logic [DW-1:0]        mem_q [2**AW];
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NPORTS-1:0]    rvalid_q, rvalid_d;
    logic [NPORTS*DW-1:0] rdata_q, rdata_d;
    logic [15:0]          cnt_q, cnt_d;

    logic [NPORTS-1:0]    gnt_s;
    logic [1:0]           slot_vld_s;
    logic [1:0]           slot_we_s;
    logic [PW-1:0]        slot_port_s [2];
    logic [AW-1:0]        slot_addr_s [2];
    logic [DW-1:0]        slot_wdata_s [2];
    logic                 conflict_s;
    logic [PW:0]          cand_s;
    logic [PW-1:0]        idx_s;
    logic [AW-1:0]        cand_addr_s;

    // Round-robin scan filling the two access slots; reset masks every grant.
    always_comb begin
        gnt_s           = '0;
        slot_vld_s      = 2'b00;
        slot_we_s       = 2'b00;
        slot_port_s[0]  = '0;
        slot_port_s[1]  = '0;
        slot_addr_s[0]  = '0;
        slot_addr_s[1]  = '0;
        slot_wdata_s[0] = '0;
        slot_wdata_s[1] = '0;
        conflict_s      = 1'b0;
        ptr_d           = ptr_q;
        cand_s          = '0;
        idx_s           = '0;
        cand_addr_s     = '0;
        for (int k = 0; k < NPORTS; k++) begin
            cand_s = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand_s >= NP_W) begin
                cand_s = cand_s - NP_W;
            end else begin
                cand_s = cand_s;
            end
            idx_s       = cand_s[PW-1:0];
            cand_addr_s = addr_i[idx_s*AW +: AW];
            if (!rst && req_i[idx_s] && !slot_vld_s[1]) begin
                if (slot_vld_s[0] && (cand_addr_s == slot_addr_s[0]) &&
                    (we_i[idx_s] || slot_we_s[0])) begin
                    conflict_s = 1'b1;
                end else if (!slot_vld_s[0]) begin
                    slot_vld_s[0]   = 1'b1;
                    slot_we_s[0]    = we_i[idx_s];
                    slot_port_s[0]  = idx_s;
                    slot_addr_s[0]  = cand_addr_s;
                    slot_wdata_s[0] = wdata_i[idx_s*DW +: DW];
                    gnt_s[idx_s]    = 1'b1;
                    ptr_d           = (idx_s == LAST_P) ? '0 : idx_s + PW'(1);
                end else begin
                    slot_vld_s[1]   = 1'b1;
                    slot_we_s[1]    = we_i[idx_s];
                    slot_port_s[1]  = idx_s;
                    slot_addr_s[1]  = cand_addr_s;
                    slot_wdata_s[1] = wdata_i[idx_s*DW +: DW];
                    gnt_s[idx_s]    = 1'b1;
                    ptr_d           = (idx_s == LAST_P) ? '0 : idx_s + PW'(1);
                end
            end else begin
                conflict_s = conflict_s;
            end
        end
    end

    // Read-return and conflict-counter next state.
    always_comb begin
        rvalid_d = gnt_s & ~we_i;
        rdata_d  = rdata_q;
        for (int s = 0; s < 2; s++) begin
            if (slot_vld_s[s] && !slot_we_s[s]) begin
                rdata_d[slot_port_s[s]*DW +: DW] = mem_q[slot_addr_s[s]];
            end else begin
                rdata_d = rdata_d;
            end
        end
        if (conflict_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            cnt_q    <= 16'd0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (slot_vld_s[s] && slot_we_s[s]) begin
                mem_q[slot_addr_s[s]] <= slot_wdata_s[s];
            end
        end
    end

    assign gnt_o          = gnt_s;
    assign rvalid_o       = rvalid_q;
    assign rdata_o        = rdata_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_dm_mport_arbiter.sv
// Self-checking bench for dm_mport_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a queue-based behavioural model.
module tb_dm_mport_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, we;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      gnt_o, rvalid_o;
    logic [N*DW-1:0]   rdata_o;
    logic [15:0]       conflict_cnt_o;

    always #5 clk = ~clk;

    dm_mport_arbiter #(.NPORTS(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .conflict_cnt_o(conflict_cnt_o)
    );

    // bench-side client requests
    bit          b_req [N];
    bit          b_we  [N];
    logic [7:0]  b_addr[N];
    logic [15:0] b_wd  [N];

    // behavioural model state
    logic [15:0] m_mem [256];
    int          m_ptr;
    logic [15:0] m_cnt;
    bit          m_rvalid[N];
    logic [15:0] m_rdata [N];
    bit          m_gnt   [N];
    bit          m_confl;
    int          m_last;

    // observed outputs sampled at the falling edge
    logic [N-1:0] o_gnt, o_rvalid;
    logic [15:0]  o_rdata[N];
    logic [15:0]  o_cnt;

    int errs = 0;
    int checks = 0;
    int waitc[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] pack(input bit v[N]);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]              = b_req[i];
            we[i]               = b_we[i];
            addr[i*AW +: AW]    = b_addr[i];
            wdata[i*DW +: DW]   = b_wd[i];
        end
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) begin
            b_req[i] = 1'b0; b_we[i] = 1'b0; b_addr[i] = 8'h00; b_wd[i] = 16'h0000;
        end
    endtask

    task automatic set_port(input int p, input bit w, input logic [7:0] a, input logic [15:0] d);
        b_req[p] = 1'b1; b_we[p] = w; b_addr[p] = a; b_wd[p] = d;
    endtask

    // Rules: visit requesters in rotated order; take up to two, skipping a
    // candidate that hits the first taken address when either side writes.
    task automatic model_grant();
        int order[$];
        int taken[$];
        int p;
        m_confl = 1'b0;
        for (int i = 0; i < N; i++) m_gnt[i] = 1'b0;
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) begin
            p = order[j];
            if (b_req[p] && taken.size() < 2) begin
                if (taken.size() == 1 && b_addr[p] == b_addr[taken[0]] && (b_we[p] || b_we[taken[0]]))
                    m_confl = 1'b1;
                else
                    taken.push_back(p);
            end
        end
        foreach (taken[j]) m_gnt[taken[j]] = 1'b1;
        m_last = (taken.size() > 0) ? taken[taken.size()-1] : -1;
    endtask

    task automatic model_commit();
        for (int p = 0; p < N; p++) begin
            m_rvalid[p] = m_gnt[p] && !b_we[p];
            if (m_rvalid[p]) m_rdata[p] = m_mem[b_addr[p]];
        end
        for (int p = 0; p < N; p++)
            if (m_gnt[p] && b_we[p]) m_mem[b_addr[p]] = b_wd[p];
        if (m_last >= 0) m_ptr = (m_last + 1) % N;
        if (m_confl && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_cnt = 16'h0000;
        for (int i = 0; i < N; i++) begin
            m_rvalid[i] = 1'b0; m_rdata[i] = 16'h0000; m_gnt[i] = 1'b0;
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        model_grant();
        o_gnt = gnt_o; o_rvalid = rvalid_o; o_cnt = conflict_cnt_o;
        for (int i = 0; i < N; i++) o_rdata[i] = rdata_o[i*DW +: DW];
        check("gnt", o_gnt, pack(m_gnt));
        check("rvalid", o_rvalid, pack(m_rvalid));
        for (int i = 0; i < N; i++) check($sformatf("rdata%0d", i), o_rdata[i], m_rdata[i]);
        check("conflict_cnt", o_cnt, m_cnt);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        drive();
        model_reset();
        #1;
        check("rst gnt", gnt_o, 4'b0000);
        check("rst rvalid", rvalid_o, 4'b0000);
        check("rst rdata", rdata_o, 64'h0);
        check("rst cnt", conflict_cnt_o, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
        rst = 1'b1;
        idle();
        drive();
        do_reset();

        // preload every address that later gets read
        for (int a = 0; a < 9; a++) begin
            idle();
            set_port(0, 1'b1, (a == 8) ? 8'h20 : 8'h40 + 8'(a), 16'($urandom));
            step();
        end
        idle();
        do_reset();

        // write then read-after-write on another port
        set_port(0, 1'b1, 8'h05, 16'h1234);
        step();
        check("w05 gnt", o_gnt, 4'b0001);
        idle();
        set_port(2, 1'b0, 8'h05, 16'h0000);
        step();
        check("r05 gnt", o_gnt, 4'b0100);
        idle();
        step();
        check("r05 rvalid", o_rvalid, 4'b0100);
        check("r05 rdata", o_rdata[2], 16'h1234);

        // same-address write/write conflict
        do_reset();
        set_port(0, 1'b1, 8'h10, 16'hAAAA);
        set_port(1, 1'b1, 8'h10, 16'hBBBB);
        step();
        check("ww c1 gnt", o_gnt, 4'b0001);
        b_req[0] = 1'b0;
        step();
        check("ww c2 gnt", o_gnt, 4'b0010);
        check("ww c2 cnt", o_cnt, 16'h0001);
        idle();
        set_port(0, 1'b0, 8'h10, 16'h0000);
        step();
        idle();
        step();
        check("ww final", o_rdata[0], 16'hBBBB);
        check("ww cnt hold", o_cnt, 16'h0001);

        // four continuous readers alternate in pairs
        do_reset();
        for (int p = 0; p < N; p++) set_port(p, 1'b0, 8'h40 + 8'(p), 16'h0000);
        step();
        check("rr c1 gnt", o_gnt, 4'b0011);
        step();
        check("rr c2 gnt", o_gnt, 4'b1100);
        check("rr c2 rvalid", o_rvalid, 4'b0011);
        step();
        check("rr c3 gnt", o_gnt, 4'b0011);
        check("rr c3 rvalid", o_rvalid, 4'b1100);
        idle();
        step();

        // two same-address reads share a cycle
        do_reset();
        set_port(0, 1'b0, 8'h40, 16'h0000);
        step();
        idle();
        set_port(1, 1'b0, 8'h20, 16'h0000);
        set_port(3, 1'b0, 8'h20, 16'h0000);
        step();
        check("rd20 gnt", o_gnt, 4'b1010);
        idle();
        step();
        check("rd20 rvalid", o_rvalid, 4'b1010);
        check("rd20 cnt", o_cnt, 16'h0000);

        // counter saturation under permanent conflict
        do_reset();
        set_port(0, 1'b1, 8'h30, 16'h1111);
        set_port(1, 1'b1, 8'h30, 16'h2222);
        repeat (65540) step();
        check("sat cnt", o_cnt, 16'hFFFF);
        idle();
        step();
        check("sat cnt hold", o_cnt, 16'hFFFF);

        // reset lands on a read grant
        idle();
        set_port(2, 1'b0, 8'h05, 16'h0000);
        drive();
        @(negedge clk);
        check("rstg gnt", gnt_o, 4'b0100);
        rst = 1'b1;
        model_reset();
        #1;
        check("rstg gnt off", gnt_o, 4'b0000);
        check("rstg cnt", conflict_cnt_o, 16'h0000);
        @(posedge clk);
        #1;
        check("rstg rvalid", rvalid_o, 4'b0000);
        rst = 1'b0;
        idle();
        step();
        check("rstg no late rvalid", o_rvalid, 4'b0000);
        set_port(1, 1'b0, 8'h05, 16'h0000);
        set_port(2, 1'b0, 8'h05, 16'h0000);
        set_port(3, 1'b0, 8'h05, 16'h0000);
        step();
        check("rstg ptr0 gnt", o_gnt, 4'b0110);
        idle();
        step();
        check("rstg rdata1", o_rdata[1], 16'h1234);
        check("rstg rdata2", o_rdata[2], 16'h1234);

        // randomized traffic: read-only phase bounds waiting, then mixed
        idle();
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int p = 0; p < N; p++) begin
                if (!b_req[p] && ($urandom % 3 != 0)) begin
                    set_port(p, (cyc < 500) ? 1'b0 : 1'($urandom % 2),
                             8'h40 + 8'($urandom % 8), 16'($urandom));
                    waitc[p] = 0;
                end
            end
            step();
            for (int p = 0; p < N; p++) begin
                if (b_req[p]) begin
                    waitc[p]++;
                    if (m_gnt[p]) begin
                        if (cyc < 500) check($sformatf("wait p%0d over bound", p), waitc[p] > N, 1'b0);
                        b_req[p] = 1'b0;
                    end
                end
            end
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
